// File: rtl/m8_word_serializer.sv
// M8 frame word serializer: fetches 12-bit words from the frame buffer by pointer
// and shifts them out MSB-first on bitTick, prefetching the next word during each shift.
module m8_word_serializer #(
    parameter int unsigned WORD_BITS = 12,
    parameter int unsigned PTR_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 bitTick,
    input  logic [WORD_BITS-1:0] dataWord,
    output logic                 bufGetWord,
    output logic [PTR_W-1:0]     bufRdPointer,
    output logic                 serOut,
    output logic                 wordStrobe,
    output logic                 frameStart,
    output logic                 busy,
    output logic                 underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SHIFT
    } state_t;

    localparam int unsigned       CNT_W    = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_BITS - 1);

    state_t                 r_state;
    logic [WORD_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bits_left;
    logic [WORD_BITS-1:0]   r_hold;
    logic [PTR_W-1:0]       r_hold_tag;
    logic                   r_hold_valid;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_get;
    logic                   r_ser;
    logic                   r_wstb;
    logic                   r_fstb;
    logic                   r_busy;
    logic                   r_underrun;

    logic                   w_tick_active;
    logic                   w_exhausted;

    // Ticks are honoured in every non-idle state, including FETCH and CAPTURE.
    assign w_tick_active = (r_state != S_IDLE) && bitTick;
    assign w_exhausted   = (r_bits_left == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bits_left  <= '0;
            r_hold       <= '0;
            r_hold_tag   <= '0;
            r_hold_valid <= 1'b0;
            r_ptr        <= '0;
            r_get        <= 1'b0;
            r_ser        <= 1'b0;
            r_wstb       <= 1'b0;
            r_fstb       <= 1'b0;
            r_busy       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_get  <= 1'b0;
            r_wstb <= 1'b0;
            r_fstb <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_FETCH;
                        r_ptr   <= '0;
                        r_get   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_hold       <= dataWord;
                    r_hold_tag   <= r_ptr;
                    r_hold_valid <= 1'b1;
                    r_state      <= S_SHIFT;
                end
                default: begin
                end
            endcase

            // Tick handling is placed after the state walk so a word boundary
            // (stop or reload) overrides the FETCH/CAPTURE progression.
            if (w_tick_active) begin
                if (!w_exhausted) begin
                    r_shift     <= r_shift << 1;
                    r_ser       <= r_shift[WORD_BITS-2];
                    r_bits_left <= r_bits_left - CNT_W'(1);
                end else if (!enable) begin
                    r_state      <= S_IDLE;
                    r_ser        <= 1'b0;
                    r_busy       <= 1'b0;
                    r_ptr        <= '0;
                    r_hold_valid <= 1'b0;
                    r_get        <= 1'b0;
                end else if (r_hold_valid) begin
                    r_shift      <= r_hold;
                    r_ser        <= r_hold[WORD_BITS-1];
                    r_bits_left  <= LAST_BIT;
                    r_hold_valid <= 1'b0;
                    r_wstb       <= 1'b1;
                    r_fstb       <= (r_hold_tag == '0);
                    r_ptr        <= r_ptr + PTR_W'(1);
                    r_get        <= 1'b1;
                    r_state      <= S_FETCH;
                end else begin
                    r_ser      <= 1'b0;
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign bufGetWord   = r_get;
    assign bufRdPointer = r_ptr;
    assign serOut       = r_ser;
    assign wordStrobe   = r_wstb;
    assign frameStart   = r_fstb;
    assign busy         = r_busy;
    assign underrun     = r_underrun;

endmodule
